// File: rtl/nts_api_pkg.sv
// Shared types and widths for the NTS API bus mux and its address decoder.
package nts_api_pkg;

    localparam int API_ADDR_W     = 12;
    localparam int API_INT_ADDR_W = 8;
    localparam int API_DATA_W     = 32;
    localparam int API_CNT_W      = 16;
    localparam int API_IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } api_state_e;

endpackage

// File: rtl/nts_api_decode.sv
// Combinational address window match with lowest-index priority.
module nts_api_decode
    import nts_api_pkg::*;
#(
    parameter int                                NUM_TARGETS = 5,
    parameter logic [NUM_TARGETS*API_ADDR_W-1:0] ADDR_BASE   = '0,
    parameter logic [NUM_TARGETS*API_ADDR_W-1:0] ADDR_STOP   = '0
) (
    input  logic [API_ADDR_W-1:0] address,
    output logic                  hit,
    output logic [API_IDX_W-1:0]  index,
    output logic [API_ADDR_W-1:0] base
);

    // Scan from the top index down so the lowest matching window wins;
    // a window with base above stop can never satisfy both bounds.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        base  = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if ((address >= ADDR_BASE[API_ADDR_W*i +: API_ADDR_W]) &&
                (address <= ADDR_STOP[API_ADDR_W*i +: API_ADDR_W])) begin
                hit   = 1'b1;
                index = API_IDX_W'(i);
                base  = ADDR_BASE[API_ADDR_W*i +: API_ADDR_W];
            end
        end
    end

endmodule

// File: rtl/nts_api_bus_mux.sv
// Registered NTS API bus mux: decodes, rebases and forwards one external
// access to an internal register bank, then returns data with ready/error.
module nts_api_bus_mux
    import nts_api_pkg::*;
#(
    parameter int                                NUM_TARGETS   = 5,
    parameter logic [NUM_TARGETS*API_ADDR_W-1:0] ADDR_BASE     =
        {12'h100, 12'h080, 12'h020, 12'h010, 12'h000},
    parameter logic [NUM_TARGETS*API_ADDR_W-1:0] ADDR_STOP     =
        {12'h1FF, 12'h0FF, 12'h03F, 12'h01F, 12'h00F},
    parameter logic [API_DATA_W-1:0]             UNMAPPED_DATA = 32'hDEAD_BEEF
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_external_api_cs,
    input  logic                              i_external_api_we,
    input  logic [API_ADDR_W-1:0]             i_external_api_address,
    input  logic [API_DATA_W-1:0]             i_external_api_write_data,
    output logic                              o_external_api_busy,
    output logic                              o_external_api_ready,
    output logic                              o_external_api_error,
    output logic [API_DATA_W-1:0]             o_external_api_read_data,
    output logic [NUM_TARGETS-1:0]            o_internal_api_cs,
    output logic                              o_internal_api_we,
    output logic [API_INT_ADDR_W-1:0]         o_internal_api_address,
    output logic [API_DATA_W-1:0]             o_internal_api_write_data,
    input  logic [NUM_TARGETS*API_DATA_W-1:0] i_internal_api_read_data,
    output logic [API_CNT_W-1:0]              o_unmapped_count
);

    function automatic logic [API_CNT_W-1:0] sat_inc(input logic [API_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    api_state_e                state_q;
    api_state_e                state_d;
    logic                      dec_hit;
    logic [API_IDX_W-1:0]      dec_idx;
    logic [API_ADDR_W-1:0]     dec_base;
    logic                      accept;
    logic                      we_p1;
    logic [API_INT_ADDR_W-1:0] addr_p1;
    logic [API_DATA_W-1:0]     wdata_p1;
    logic                      hit_p1;
    logic [API_IDX_W-1:0]      idx_p1;
    logic [API_DATA_W-1:0]     rdata_p2;
    logic [API_CNT_W-1:0]      cnt_q;

    nts_api_decode #(
        .NUM_TARGETS (NUM_TARGETS),
        .ADDR_BASE   (ADDR_BASE),
        .ADDR_STOP   (ADDR_STOP)
    ) u_decode (
        .address (i_external_api_address),
        .hit     (dec_hit),
        .index   (dec_idx),
        .base    (dec_base)
    );

    assign accept = (state_q == IDLE) && i_external_api_cs;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_external_api_cs) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: request latched on acceptance; offset truncation to 8 bits aliases wide windows.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            we_p1    <= i_external_api_we;
            addr_p1  <= API_INT_ADDR_W'(i_external_api_address - dec_base);
            wdata_p1 <= i_external_api_write_data;
            hit_p1   <= dec_hit;
            idx_p1   <= dec_idx;
        end
    end

    // Stage p2: target data arrives the cycle after its chip select.
    always_ff @(posedge i_clk) begin
        if (state_q == WAIT) begin
            if (we_p1) begin
                rdata_p2 <= '0;
            end else if (!hit_p1) begin
                rdata_p2 <= UNMAPPED_DATA;
            end else begin
                rdata_p2 <= i_internal_api_read_data[API_DATA_W*idx_p1 +: API_DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if ((state_q == RESP) && !hit_p1) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    always_comb begin
        o_external_api_busy       = 1'b0;
        o_external_api_ready      = 1'b0;
        o_external_api_error      = 1'b0;
        o_external_api_read_data  = '0;
        o_internal_api_cs         = '0;
        o_internal_api_we         = 1'b0;
        o_internal_api_address    = '0;
        o_internal_api_write_data = '0;
        if (state_q != IDLE) begin
            o_external_api_busy       = 1'b1;
            o_internal_api_we         = we_p1;
            o_internal_api_address    = addr_p1;
            o_internal_api_write_data = wdata_p1;
        end
        if ((state_q == ISSUE) && hit_p1) begin
            o_internal_api_cs = NUM_TARGETS'(1) << idx_p1;
        end
        if (state_q == RESP) begin
            o_external_api_ready     = 1'b1;
            o_external_api_error     = !hit_p1;
            o_external_api_read_data = rdata_p2;
        end
    end

    assign o_unmapped_count = cnt_q;

endmodule
